// File: rtl/input_port_buffer.sv
// Purpose : per-input-port flit FIFO plus packet sequencer feeding the output-port arbiter.
// Latency : a write is at the head next cycle; a header at the head raises req/length one cycle later (2 cycles write-to-request).
// Backpressure: full stalls upstream writes unless a pop happens in the same cycle; pops are only honoured while a packet is ACTIVE.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   wr_en, flit_in      upstream write strobe and flit
//   full, empty         FIFO occupancy flags
//   rd_en               pop strobe from the arbiter when this port is granted
//   flit_out, flit_id   head flit and its 3-bit type (0 when empty)
//   length, req         length latched from the current header, one-hot {S,W,E,N,L} request
//   err                 sticky flag: a non-header flit was dropped while idle
module input_port_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] flit_in,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  empty,
  output logic [2:0]            flit_id,
  output logic [11:0]           length,
  output logic [4:0]            req,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] TYPE_HEADER = 3'b001;
  localparam logic [2:0] TYPE_TAIL   = 3'b100;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;
  state_t                state;

  logic [2:0] head_type;
  logic       auto_pop;
  logic       pop_acc;
  logic       pop;
  logic       push;

  function automatic logic [4:0] dest_onehot(input logic [2:0] dest);
    case (dest)
      3'd1:    dest_onehot = 5'b00010;  // N
      3'd2:    dest_onehot = 5'b00100;  // E
      3'd3:    dest_onehot = 5'b01000;  // W
      3'd4:    dest_onehot = 5'b10000;  // S
      default: dest_onehot = 5'b00001;  // L, also catches unused codes 5-7
    endcase
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign flit_out  = mem[rd_ptr];
  assign head_type = flit_out[2:0];
  assign flit_id   = empty ? 3'b000 : head_type;

  // A stray body/tail at the head while idle has no packet to belong to, so it is discarded.
  assign auto_pop = (state == IDLE) && !empty && (head_type != TYPE_HEADER);
  assign pop_acc  = rd_en && !empty && (state == ACTIVE);
  assign pop      = pop_acc || auto_pop;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
  assign push     = wr_en && (!full || pop);

  // Storage is deliberately not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: the header stays at the head while it is decoded; the arbiter pops it once granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      req    <= '0;
      length <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_type == TYPE_HEADER) begin
              length <= flit_out[14:3];
              req    <= dest_onehot(flit_out[17:15]);
              state  <= ACTIVE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (pop_acc && (head_type == TYPE_TAIL)) begin
            req   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/input_port_buffer.md
# input_port_buffer

Per-input-port flit FIFO and packet sequencer that sits directly upstream of the router's output-port `arbiter`. It buffers incoming flits and decodes each packet header for destination and length. While a packet occupies the FIFO head it holds a one-hot request toward the addressed output. It presents the head flit's 3-bit flit id and the 12-bit packet length in the form the arbiter's per-port `timer` loads them.

## Interface
- `DATA_WIDTH`, 32: flit width; must be ≥ 18.
- `DEPTH`, 4: FIFO entries; power of 2, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe from upstream link.
- `flit_in`  in  DATA_WIDTH  incoming flit.
- `full`  out  1  FIFO holds DEPTH flits.
- `rd_en`  in  1  pop strobe from downstream, issued when this port is granted.
- `flit_out`  out  DATA_WIDTH  head flit (combinational from storage).
- `empty`  out  1  FIFO holds 0 flits.
- `flit_id`  out  3  `flit_out[2:0]` when not empty, else 3'b000.
- `length`  out  12  length field latched from the current header.
- `req`  out  5  one-hot request, bit order {S,W,E,N,L}.
- `err`  out  1  sticky: a non-header flit was dropped in IDLE.

## Operation
- Flit format:
  - [2:0] type: 3'b001 header, 3'b010 body, 3'b100 tail.
  - [14:3] length (header only).
  - [17:15] destination: 0=L, 1=N, 2=E, 3=W, 4=S; codes 5–7 route to L.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count of log2(DEPTH)+1 bits.
  - `full` = (count == DEPTH); `empty` = (count == 0).
- Write is accepted when `wr_en` and (!`full` or accepted pop in the same cycle).
- Write when full with no pop is ignored; storage is unchanged.
- Pop is accepted only when `rd_en`, !`empty` and state == ACTIVE.
- Pop in IDLE or when empty is ignored.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- State machine, states IDLE and ACTIVE:
  - IDLE, head is a header (!empty, type 001):
    - Latch `length` ← [14:3].
    - `req` ← one-hot of decoded destination.
    - Go to ACTIVE. The header is not popped here.
  - IDLE, head is a non-header flit:
    - Auto-pop it and set `err`.
    - Remain in IDLE.
  - IDLE, empty: remain in IDLE.
  - ACTIVE, `req` held constant.
  - ACTIVE, accepted pop of a flit with type 100 (tail):
    - `req` ← 0.
    - Go to IDLE.
  - A header popped in ACTIVE does not re-latch anything.
- `length` holds its value until the next header latch.
- `err` is cleared only by reset.
- Reset (any time, including mid-packet):
  - Pointers, count, state=IDLE, `req`=0, `length`=0, `err`=0.
  - `empty`=1, `full`=0, `flit_id`=0.
  - Storage contents are not cleared and are don't-care.

## Timing
- Write at edge t: `empty` falls after edge t, and the flit is visible on `flit_out`/`flit_id` in cycle t+1.
- Header visible at head in cycle t+1: `req`/`length` are registered at edge t+1 and valid from cycle t+2.
- Write-to-request latency is therefore 2 cycles.
- Tail popped at edge p:
  - `req` is 0 after edge p.
  - Next header at head is decoded at edge p+1, giving req from p+2.
  - `req` is therefore low for exactly one cycle between back-to-back packets.
- `req` never changes while ACTIVE, whatever happens on `rd_en`, `wr_en` or `full`.

## Test plan
- Reset, then write header (dest=2, length=12'h00A), body, tail:
  - `req`=5'b00100 two cycles after the header write, and `length`=10.
  - `flit_id`=001 while the header is at head.
  - Pop 3 times: `req` returns to 0 after the tail pop, and `empty`=1.
- Fill with DEPTH flits without popping:
  - `full`=1.
  - Extra write is ignored: count stays DEPTH and contents are unchanged.
  - Write plus pop while full: both are accepted and `full` stays 1.
- Write body flit into idle port:
  - It is auto-dropped the next cycle and `err`=1.
  - `req` stays 0; `err` persists until reset.
- Two back-to-back packets (dest=4 then dest=0):
  - `req` goes 10000, then 00000 for one cycle, then 00001.
- Header with dest=6: `req`=5'b00001.
- Assert `rst` mid-packet (asynchronously, mid-cycle):
  - `req`=0, `empty`=1, `length`=0 immediately.
  - After release, a new packet is handled normally.
